// File: rtl/daq_raw_fmt.sv
// Raw-hit readout formatter: per request, fetches one frame per time bin
// from the raw hit memory, serialises layers into CHUNK-bit words with
// optional layer/time-bin zero suppression, pads to a multiple of four
// words and closes the frame with a word-count trailer.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a readout request
// HDR    | header word presented, waiting for it to transfer
// FETCH  | raw memory read strobe for the current time bin
// LOAD   | raw memory data captured into the frame buffer
// EMIT   | walking layers/chunks of the buffered time bin
// PAD    | emitting pad words until the frame length fits, then trailer
// TRAIL  | trailer presented, waiting for it to transfer
module daq_raw_fmt #(
  parameter int NLAYERS = 6,
  parameter int LYW     = 64,
  parameter int CHUNK   = 12,
  parameter int AW      = 8,
  parameter int TBW     = 5
) (
  input  logic                     clk,
  input  logic                     hard_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic [TBW-1:0]           req_tbins,
  input  logic                     zs,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic [NLAYERS*LYW-1:0]   rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHUNK+1:0]         out_data,
  output logic                     busy
);

  localparam int NCH = (LYW + CHUNK - 1) / CHUNK;
  localparam int LIW = (NLAYERS > 1) ? $clog2(NLAYERS) : 1;
  localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WCW = CHUNK - 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_PAD   = 3'd5;
  localparam logic [2:0] S_TRAIL = 3'd6;

  localparam logic [1:0] T_DATA  = 2'b00;
  localparam logic [1:0] T_LAYER = 2'b01;
  localparam logic [1:0] T_TBIN  = 2'b10;
  localparam logic [1:0] T_CTRL  = 2'b11;

  localparam logic [3:0] K_HDR   = 4'hA;
  localparam logic [3:0] K_PAD   = 4'h3;
  localparam logic [3:0] K_TRAIL = 4'hE;

  localparam logic [LIW-1:0] LAST_LYR = LIW'(NLAYERS - 1);
  localparam logic [CIW-1:0] LAST_CHK = CIW'(NCH - 1);

  logic [2:0]               state;
  logic [AW-1:0]            base_q;
  logic [TBW-1:0]           tbins_q;
  logic                     zs_q;
  logic [TBW-1:0]           tb;
  logic [LIW-1:0]           lyr;
  logic [CIW-1:0]           chk;
  logic [WCW-1:0]           wc;
  logic                     emit_done;
  logic [NLAYERS*LYW-1:0]   frame_buf;

  logic [LYW-1:0]           layer_bits;
  logic [NCH*CHUNK-1:0]     layer_ext;
  logic                     bin_zero;
  logic                     layer_zero;

  logic                     gen_valid;
  logic                     gen_last;
  logic                     gen_trail;
  logic [CHUNK+1:0]         gen_word;

  logic                     load;
  logic                     xfer;
  logic                     accept;
  logic [TBW:0]             tb_next;
  logic                     more_bins;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;
  assign rd_en     = (state == S_FETCH);
  // Address wraps modulo 2^AW; held at zero outside the read strobe.
  assign rd_addr   = (state == S_FETCH) ? base_q + AW'(tb) : '0;

  // The output register accepts a new word whenever it is empty or draining.
  assign load      = gen_valid & (~out_valid | out_ready);
  assign xfer      = out_valid & out_ready;

  assign tb_next   = {1'b0, tb} + 1'b1;
  assign more_bins = (tb_next < {1'b0, tbins_q});

  // Select the current layer and zero-extend it to a whole number of chunks.
  always_comb begin
    layer_bits = frame_buf[int'(lyr)*LYW +: LYW];
    layer_ext  = '0;
    layer_ext[LYW-1:0] = layer_bits;
    bin_zero   = (frame_buf == '0);
    layer_zero = (layer_bits == '0);
  end

  // Next-word generator: what the output register would take next.
  always_comb begin
    gen_valid = 1'b0;
    gen_last  = 1'b0;
    gen_trail = 1'b0;
    gen_word  = '0;
    case (state)
      S_IDLE: begin
        gen_valid = req_valid;
        gen_word  = {T_CTRL, K_HDR, WCW'(req_tbins)};
      end
      S_EMIT: begin
        if (!emit_done) begin
          gen_valid = 1'b1;
          if (zs_q && bin_zero) begin
            gen_word = {T_TBIN, CHUNK'(tb)};
            gen_last = 1'b1;
          end else if (zs_q && layer_zero) begin
            gen_word = {T_LAYER, CHUNK'(lyr)};
            gen_last = (lyr == LAST_LYR);
          end else begin
            gen_word = {T_DATA, layer_ext[int'(chk)*CHUNK +: CHUNK]};
            gen_last = (lyr == LAST_LYR) && (chk == LAST_CHK);
          end
        end
      end
      S_PAD: begin
        gen_valid = 1'b1;
        if (wc[1:0] == 2'b11) begin
          gen_trail = 1'b1;
          gen_word  = {T_CTRL, K_TRAIL, wc};
        end else begin
          gen_word  = {T_CTRL, K_PAD, {WCW{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  // Output register and running word count (header counts as the first word).
  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      wc        <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= gen_word;
        if (!gen_trail) begin
          wc <= (state == S_IDLE) ? WCW'(1) : wc + 1'b1;
        end
      end
    end
  end

  // Frame sequencing: request latch, time-bin walk and layer/chunk walk.
  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      tbins_q   <= '0;
      zs_q      <= 1'b0;
      tb        <= '0;
      lyr       <= '0;
      chk       <= '0;
      emit_done <= 1'b0;
      frame_buf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            base_q  <= req_addr;
            tbins_q <= req_tbins;
            zs_q    <= zs;
            tb      <= '0;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (xfer) begin
            state <= (tbins_q == '0) ? S_PAD : S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          frame_buf <= rd_data;
          lyr       <= '0;
          chk       <= '0;
          emit_done <= 1'b0;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (load) begin
            if (gen_last) begin
              emit_done <= 1'b1;
            end else if ((zs_q && layer_zero) || (chk == LAST_CHK)) begin
              lyr <= lyr + 1'b1;
              chk <= '0;
            end else begin
              chk <= chk + 1'b1;
            end
          end
          // Leave only once the last word of the bin has gone downstream,
          // so nothing is pending while the next read is in flight.
          if (emit_done && xfer) begin
            emit_done <= 1'b0;
            if (more_bins) begin
              tb    <= tb + 1'b1;
              state <= S_FETCH;
            end else begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (load && gen_trail) begin
            state <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (xfer) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_daq_raw_fmt.sv
// Bench for daq_raw_fmt: a frame model built from the word-format rules
// (header, per-bin/per-layer suppression, chunking, padding, trailer) is
// compared against every transferred word, plus read-address order and
// output stability while stalled.
module tb_daq_raw_fmt;

  localparam int NL     = 6;
  localparam int LYW    = 64;
  localparam int CHUNK  = 12;
  localparam int AW     = 8;
  localparam int TBW    = 5;
  localparam int DW     = NL * LYW;
  localparam int BUDGET = 6000;

  logic               clk = 1'b0;
  logic               hard_rst;
  logic               req_valid;
  logic               req_ready;
  logic [AW-1:0]      req_addr;
  logic [TBW-1:0]     req_tbins;
  logic               zs;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [CHUNK+1:0]   out_data;
  logic               busy;

  logic [DW-1:0]      mem [256];
  logic [CHUNK+1:0]   exp_q [$];
  logic [AW-1:0]      addr_q [$];

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  bit rnd_ready = 1'b0;

  daq_raw_fmt dut (
    .clk       (clk),
    .hard_rst  (hard_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_tbins (req_tbins),
    .zs        (zs),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  // Expected frame from the format rules.
  task automatic build_exp(input logic [AW-1:0] a, input int nt, input bit z);
    int            wc;
    logic [DW-1:0] d;
    logic [63:0]   lay;
    logic [AW-1:0] ad;
    wc = 0;
    exp_q.push_back({2'b11, 4'hA, 8'(nt)});
    wc++;
    for (int t = 0; t < nt; t++) begin
      ad = AW'(int'(a) + t);
      addr_q.push_back(ad);
      d = mem[ad];
      if (z && d == '0) begin
        exp_q.push_back({2'b10, 12'(t)});
        wc++;
      end else begin
        for (int k = 0; k < NL; k++) begin
          lay = d[k*LYW +: LYW];
          if (z && lay == 64'd0) begin
            exp_q.push_back({2'b01, 12'(k)});
            wc++;
          end else begin
            for (int c = 0; c < (LYW + CHUNK - 1) / CHUNK; c++) begin
              exp_q.push_back({2'b00, 12'((lay >> (c * CHUNK)) & 64'hFFF)});
              wc++;
            end
          end
        end
      end
    end
    while (wc % 4 != 3) begin
      exp_q.push_back(14'h3300);
      wc++;
    end
    exp_q.push_back({2'b11, 4'hE, 8'(wc % 256)});
  endtask

  function automatic logic [DW-1:0] inc_pattern();
    logic [DW-1:0] v;
    v = '0;
    for (int b = 0; b < DW / 8; b++) v[b*8 +: 8] = 8'(b);
    return v;
  endfunction

  task automatic do_req(input logic [AW-1:0] a, input int nt, input bit z);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("req_ready_timeout");
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_tbins = TBW'(nt);
    zs        = z;
    @(negedge clk);
    req_valid = 1'b0;
    chk("hdr_valid_t1", out_valid, 1);
    chk("busy_t1", busy, 1);
    chk("req_ready_t1", req_ready, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("frame_timeout");
      exp_q.delete();
      addr_q.delete();
      return;
    end
    @(negedge clk);
    chk("req_ready_after", req_ready, 1);
    chk("busy_after", busy, 0);
    chk("reads_done", addr_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
  endtask

  // Raw memory: data valid the cycle after the read strobe.
  initial begin
    rd_data = '0;
    forever begin
      @(posedge clk);
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  // Downstream ready, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Word compare and stall-stability check.
  initial begin : out_cmp
    logic             stalled;
    logic [CHUNK+1:0] held;
    logic [CHUNK+1:0] e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!hard_rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("word", out_data, e);
          end
          n_xfer++;
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  // Read address order; nothing presented downstream while reading.
  initial begin
    forever begin
      @(negedge clk);
      if (hard_rst && rd_en) begin
        if (addr_q.size() == 0) fail("unexpected_read");
        else chk("rd_addr", rd_addr, addr_q.pop_front());
        chk("valid_low_fetch", out_valid, 0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int            base;
    int            n;
    logic [DW-1:0] d;
    hard_rst  = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_tbins = '0;
    zs        = 1'b0;
    for (int i = 0; i < 256; i++) begin
      d = '0;
      if ($urandom_range(0, 5) != 0)
        for (int k = 0; k < NL; k++)
          if ($urandom_range(0, 2) != 0) d[k*LYW +: LYW] = {$urandom, $urandom};
      mem[i] = d;
    end
    repeat (3) @(negedge clk);
    check_reset_vals();
    hard_rst = 1'b1;

    // Empty frame: header, two pads, trailer.
    rnd_ready = 1'b0;
    build_exp(8'h10, 0, 1'b0);
    chk("m_t0_len", exp_q.size(), 4);
    chk("m_t0_hdr", exp_q[0], 14'h3A00);
    chk("m_t0_pad", exp_q[1], 14'h3300);
    chk("m_t0_trl", exp_q[3], 14'h3E03);
    do_req(8'h10, 0, 1'b0);
    wait_done();

    // One bin, no suppression, incrementing bytes.
    mem[8'h20] = inc_pattern();
    build_exp(8'h20, 1, 1'b0);
    chk("m_inc_len", exp_q.size(), 40);
    chk("m_inc_c0", exp_q[1], 14'h0100);
    chk("m_inc_c1", exp_q[2], 14'h0020);
    chk("m_inc_l5c5", exp_q[36], 14'h0002);
    chk("m_inc_trl", exp_q[39], 14'h3E27);
    do_req(8'h20, 1, 1'b0);
    wait_done();

    // Two all-zero bins with suppression.
    rnd_ready = 1'b1;
    mem[8'h30] = '0;
    mem[8'h31] = '0;
    build_exp(8'h30, 2, 1'b1);
    chk("m_zb_len", exp_q.size(), 4);
    chk("m_zb_b0", exp_q[1], 14'h2000);
    chk("m_zb_b1", exp_q[2], 14'h2001);
    chk("m_zb_trl", exp_q[3], 14'h3E03);
    do_req(8'h30, 2, 1'b1);
    wait_done();

    // Only layer 2 nonzero with suppression.
    d = '0;
    d[2*LYW +: LYW] = 64'h0123456789ABCDEF;
    mem[8'h40] = d;
    build_exp(8'h40, 1, 1'b1);
    chk("m_l2_len", exp_q.size(), 16);
    chk("m_l2_e0", exp_q[1], 14'h1000);
    chk("m_l2_e1", exp_q[2], 14'h1001);
    chk("m_l2_c0", exp_q[3], 14'h0DEF);
    chk("m_l2_e3", exp_q[9], 14'h1003);
    chk("m_l2_pad", exp_q[12], 14'h3300);
    chk("m_l2_trl", exp_q[15], 14'h3E0F);
    do_req(8'h40, 1, 1'b1);
    wait_done();

    // Address wrap.
    build_exp(8'hFF, 3, 1'b0);
    chk("m_wrap_a0", addr_q[0], 8'hFF);
    chk("m_wrap_a1", addr_q[1], 8'h00);
    chk("m_wrap_a2", addr_q[2], 8'h01);
    do_req(8'hFF, 3, 1'b0);
    wait_done();

    // Reset in the middle of a bin, then a clean frame.
    rnd_ready = 1'b0;
    mem[8'h50] = inc_pattern();
    build_exp(8'h50, 2, 1'b0);
    do_req(8'h50, 2, 1'b0);
    base = n_xfer;
    n = 0;
    while (n_xfer < base + 8 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n_xfer < base + 8) fail("abort_progress_timeout");
    @(posedge clk);
    #2;
    hard_rst = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    hard_rst = 1'b1;
    rnd_ready = 1'b1;
    build_exp(8'h50, 2, 1'b0);
    do_req(8'h50, 2, 1'b0);
    wait_done();

    // Randomised frames.
    for (int f = 0; f < 12; f++) begin
      logic [AW-1:0] a;
      int            nt;
      bit            z;
      a         = AW'($urandom_range(0, 255));
      nt        = $urandom_range(0, 6);
      z         = 1'($urandom_range(0, 1));
      rnd_ready = 1'($urandom_range(0, 1));
      build_exp(a, nt, z);
      do_req(a, nt, z);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
